// File: rtl/store_buffer_fwd.sv
// In-order store buffer with speculative/retired regions, memory drain port and
// youngest-match load forwarding across every live entry.
module store_buffer_fwd #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              retire,
  input  logic              flush,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hit,
  output logic [DATA_W-1:0] ld_data,
  output logic [IDX_W:0]    count,
  output logic              full,
  output logic              empty
);

  // Pointers carry one extra wrap bit so full (distance DEPTH) differs from empty.
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  cmt_q, cmt_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  cnt;
  logic              enq;
  logic              ret;
  logic              drn;

  // Occupancy and status flags come straight from the registered pointers.
  assign cnt      = head_q - tail_q;
  assign count    = cnt;
  assign full     = (cnt == PTR_W'(DEPTH));
  assign empty    = (cnt == '0);
  assign in_ready = !full;

  // Drain port presents the oldest retired entry.
  assign mem_valid = (tail_q != cmt_q);
  assign mem_addr  = addr_mem[tail_q[IDX_W-1:0]];
  assign mem_data  = data_mem[tail_q[IDX_W-1:0]];

  // Pointer next-state: flush rewinds head to the post-retire commit point.
  always_comb begin
    enq    = in_valid && !full && !flush;
    ret    = retire && (cmt_q != head_q);
    drn    = mem_valid && mem_ready;
    cmt_d  = cmt_q + PTR_W'(ret);
    head_d = flush ? cmt_d : head_q + PTR_W'(enq);
    tail_d = tail_q + PTR_W'(drn);
  end

  // Pointer registers; async reset drops mem_valid without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      cmt_q  <= cmt_d;
      tail_q <= tail_d;
    end
  end

  // Entry storage needs no reset; only slots inside [tail, head) are ever observed.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[head_q[IDX_W-1:0]] <= in_addr;
      data_mem[head_q[IDX_W-1:0]] <= in_data;
    end
  end

  // Per-age compare: offset k from tail is live when k < count.
  logic [DEPTH-1:0] match;
  logic [IDX_W-1:0] slot [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
    assign slot[k]  = tail_q[IDX_W-1:0] + IDX_W'(k);
    assign match[k] = (PTR_W'(k) < cnt) && (addr_mem[slot[k]] == ld_addr);
  end

  // Forwarding select: scan oldest to youngest so the youngest match wins.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[k]) begin
        ld_hit  = 1'b1;
        ld_data = data_mem[slot[k]];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer_fwd.sv
// Self-checking bench for store_buffer_fwd: reference model plus a scoreboard of
// expected memory writes pushed at retire and popped on each drain transfer.
module tb_store_buffer_fwd;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int IDX_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              retire;
  logic              flush;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_data;
  logic [IDX_W:0]    count;
  logic              full;
  logic              empty;

  store_buffer_fwd #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .retire   (retire),
    .flush    (flush),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .ld_addr  (ld_addr),
    .ld_hit   (ld_hit),
    .ld_data  (ld_data),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_xfer   = 0;

  // Reference model: unbounded pointers, slot = pointer mod DEPTH.
  int          m_head;
  int          m_cmt;
  int          m_tail;
  logic [15:0] m_addr [DEPTH];
  logic [7:0]  m_data [DEPTH];
  logic [23:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_head = 0;
    m_cmt  = 0;
    m_tail = 0;
    exp_q.delete();
  endtask

  task automatic set_in(input logic v, input logic [15:0] a, input logic [7:0] d,
                        input logic r, input logic f, input logic mr);
    in_valid  = v;
    in_addr   = a;
    in_data   = d;
    retire    = r;
    flush     = f;
    mem_ready = mr;
  endtask

  // One clock: compare outputs at negedge, then advance the model at posedge.
  task automatic tick();
    int          cnt_m;
    logic        hit_m;
    logic [7:0]  dat_m;
    logic [23:0] e;
    logic        enq;
    logic        ret;
    logic        drn;
    @(negedge clk);
    cnt_m = m_head - m_tail;
    hit_m = 1'b0;
    dat_m = '0;
    for (int j = m_tail; j < m_head; j++) begin
      if (m_addr[j % DEPTH] == ld_addr) begin
        hit_m = 1'b1;
        dat_m = m_data[j % DEPTH];
      end
    end
    check("count", 32'(count), 32'(cnt_m));
    check("full", 32'(full), 32'(cnt_m == DEPTH));
    check("empty", 32'(empty), 32'(cnt_m == 0));
    check("in_ready", 32'(in_ready), 32'(cnt_m != DEPTH));
    check("mem_valid", 32'(mem_valid), 32'(m_cmt != m_tail));
    check("ld_hit", 32'(ld_hit), 32'(hit_m));
    check("ld_data", 32'(ld_data), 32'(dat_m));
    if (mem_valid && mem_ready) begin
      n_xfer++;
      check("xfer_queued", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("mem_addr", 32'(mem_addr), 32'(e[23:8]));
        check("mem_data", 32'(mem_data), 32'(e[7:0]));
      end
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      enq = in_valid && (cnt_m != DEPTH) && !flush;
      ret = retire && (m_cmt != m_head);
      drn = (m_cmt != m_tail) && mem_ready;
      if (ret) begin
        exp_q.push_back({m_addr[m_cmt % DEPTH], m_data[m_cmt % DEPTH]});
        m_cmt++;
      end
      if (enq) begin
        m_addr[m_head % DEPTH] = in_addr;
        m_data[m_head % DEPTH] = in_data;
      end
      if (flush) m_head = m_cmt;
      else if (enq) m_head++;
      if (drn) m_tail++;
    end
    #1;
  endtask

  // Retire and drain everything that remains, bounded.
  task automatic drain_all();
    set_in(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (m_head == m_tail) break;
      tick();
    end
    check("drain_empty", 32'(empty), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int x0;
    set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    ld_addr = 16'h0;
    model_reset();
    #1;
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ld_hit", 32'(ld_hit), 32'd0);
    check("rst_ld_data", 32'(ld_data), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Two stores, retired and drained in order.
    x0 = n_xfer;
    set_in(1'b1, 16'h1000, 8'hAA, 1'b0, 1'b0, 1'b1); tick();
    set_in(1'b1, 16'h1001, 8'hBB, 1'b0, 1'b0, 1'b1); tick();
    set_in(1'b0, '0, '0, 1'b1, 1'b0, 1'b1); tick();
    tick();
    drain_all();
    check("t1_xfers", 32'(n_xfer - x0), 32'd2);

    // Fill to DEPTH, overflow dropped, drain one slot then refill.
    ld_addr = 16'hFFFF;
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 16'h2000 + 16'(i), 8'(i + 1), 1'b0, 1'b0, 1'b0);
      tick();
    end
    check("t2_full", 32'(full), 32'd1);
    set_in(1'b1, 16'h2FFF, 8'hEE, 1'b0, 1'b0, 1'b0);
    check("t2_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("t2_count16", 32'(count), 32'd16);
    set_in(1'b0, '0, '0, 1'b1, 1'b0, 1'b0); tick();
    set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b1); tick();
    check("t2_count15", 32'(count), 32'd15);
    set_in(1'b1, 16'h2100, 8'h77, 1'b0, 1'b0, 1'b0); tick();
    check("t2_refill", 32'(count), 32'd16);
    drain_all();

    // Flush with a same-cycle enqueue keeps only the retired store.
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 16'h3000 + 16'(i), 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b0, '0, '0, 1'b1, 1'b0, 1'b0); tick();
    set_in(1'b1, 16'h3FFF, 8'h99, 1'b0, 1'b1, 1'b0); tick();
    check("t3_count", 32'(count), 32'd1);
    x0 = n_xfer;
    drain_all();
    check("t3_xfers", 32'(n_xfer - x0), 32'd1);

    // Youngest-match forwarding.
    set_in(1'b1, 16'h0020, 8'h11, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, 16'h0030, 8'h22, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, 16'h0020, 8'h33, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    ld_addr = 16'h0020; #1;
    check("t4_hit20", 32'(ld_hit), 32'd1);
    check("t4_data20", 32'(ld_data), 32'h33);
    ld_addr = 16'h0040; #1;
    check("t4_hit40", 32'(ld_hit), 32'd0);
    check("t4_data40", 32'(ld_data), 32'd0);
    ld_addr = 16'h0030;
    tick();
    set_in(1'b0, '0, '0, 1'b0, 1'b1, 1'b0); tick();
    check("t4_flushed", 32'(count), 32'd0);

    // Random traffic; pointers wrap several times.
    for (int i = 0; i < 160; i++) begin
      set_in(1'($urandom_range(0, 3) != 0), 16'h0040 + 16'($urandom_range(0, 3)),
             8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));
      ld_addr = 16'h0040 + 16'($urandom_range(0, 4));
      tick();
    end
    drain_all();

    // Async reset in the middle of a stalled drain.
    set_in(1'b1, 16'h5000, 8'h5A, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b0, '0, '0, 1'b1, 1'b0, 1'b0); tick();
    set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b0); tick();
    check("t6_valid_pre", 32'(mem_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_valid_rst", 32'(mem_valid), 32'd0);
    check("t6_count_rst", 32'(count), 32'd0);
    check("t6_empty_rst", 32'(empty), 32'd1);
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    x0 = n_xfer;
    set_in(1'b1, 16'h5100, 8'hA5, 1'b0, 1'b0, 1'b0); tick();
    drain_all();
    check("t6_xfers", 32'(n_xfer - x0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
